// File: rtl/pp_shift_accumulator.sv
// -----------------------------------------------------------------------------
// pp_shift_accumulator
//
// Final stage of the byte-serial 32x32 multiply path. It accepts NBEATS
// shifted partial products, least significant multiplier byte first. Beat k is
// weighted by 2^(8k). The full product sum is then offered on a valid/ready
// output.
//
// Optional feature macro: PP_ACC_OVF_EN
//   When defined, the sticky overflow output 'ovf' is present. It is raised when
//   an add carries out of the accumulator, or when a shifted beat loses
//   nonzero bits above ACC_W-1.
//   When undefined, truncation mod 2^ACC_W is silent and the port does not
//   exist.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clr        in   1      synchronous abort: drop partial sum / pending result
//   in_valid   in   1      in_data valid
//   in_ready   out  1      accumulator can take a beat (ACCUM state)
//   in_data    in   IN_W   shifted partial product for the current beat
//   out_valid  out  1      out_data holds a finished sum (DONE state)
//   out_ready  in   1      downstream accepts out_data
//   out_data   out  ACC_W  accumulated result, held until the handshake
//   ovf        out  1      sticky overflow flag (PP_ACC_OVF_EN only)
// -----------------------------------------------------------------------------
module pp_shift_accumulator #(
  parameter int IN_W   = 48,
  parameter int ACC_W  = 72,
  parameter int NBEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
`ifdef PP_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SHIFT_MAX = 8 * (NBEATS - 1);
  localparam int RAW_W     = IN_W + SHIFT_MAX;
  // One spare bit above the widest possible shifted beat. This keeps the
  // "lost bits" slice non-empty even when ACC_W covers the whole shifted beat.
  localparam int WIDE_W    = ((RAW_W > ACC_W) ? RAW_W : ACC_W) + 1;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   w_beat_cnt_next;
  logic [ACC_W-1:0]   r_out_data;
  logic [ACC_W-1:0]   w_out_data_next;

  logic               w_accept;
  logic               w_last;
  logic [CNT_W+2:0]   w_shamt;
  logic [WIDE_W-1:0]  w_wide;
  logic [ACC_W:0]     w_sum;

  assign w_accept = in_valid && (r_state == S_ACCUM);
  assign w_last   = (r_beat_cnt == CNT_W'(NBEATS - 1));
  assign w_shamt  = {r_beat_cnt, 3'b000};
  assign w_wide   = WIDE_W'(in_data) << w_shamt;
  // Extra top bit captures the carry out of the accumulator.
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_wide[ACC_W-1:0]};

  // ---------------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ACCUM;
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_acc      <= w_acc_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_out_data <= w_out_data_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic. clr overrides any beat or handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_acc_next      = r_acc;
    w_beat_cnt_next = r_beat_cnt;
    w_out_data_next = r_out_data;

    if (clr) begin
      w_state_next    = S_ACCUM;
      w_acc_next      = '0;
      w_beat_cnt_next = '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (in_valid) begin
            w_acc_next = w_sum[ACC_W-1:0];
            if (w_last) begin
              // The final beat is folded into the result in the same cycle.
              w_out_data_next = w_sum[ACC_W-1:0];
              w_beat_cnt_next = '0;
              w_state_next    = S_DONE;
            end else begin
              w_beat_cnt_next = r_beat_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_next    = S_ACCUM;
            w_acc_next      = '0;
            w_beat_cnt_next = '0;
          end
        end
        default: begin
          w_state_next = S_ACCUM;
        end
      endcase
    end
  end

  // Keep in_ready low while reset is asserted, so nothing is accepted until
  // the reset is released.
  assign in_ready  = rst_n && (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;

`ifdef PP_ACC_OVF_EN
  logic r_ovf;
  logic w_ovf_next;
  logic w_lost;

  assign w_lost = |w_wide[WIDE_W-1:ACC_W];

  always_comb begin
    w_ovf_next = r_ovf;
    if (clr) begin
      w_ovf_next = 1'b0;
    end else if (w_accept) begin
      w_ovf_next = r_ovf | w_sum[ACC_W] | w_lost;
    end else if ((r_state == S_DONE) && out_ready) begin
      w_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_next;
    end
  end

  assign ovf = r_ovf;
`else
  // Carry and discarded bits only matter for the overflow flag.
  logic [WIDE_W-ACC_W:0] w_unused_bits;
  assign w_unused_bits = {w_wide[WIDE_W-1:ACC_W], w_sum[ACC_W], w_accept};
`endif

endmodule
